// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential 32-bit binary to 8-digit packed BCD converter with hex pass-through
module bin2bcd_seq #(
  parameter logic [31:0] ERR_PATTERN = 32'hEEEEEEEE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        hex_mode,
  input  logic [31:0] bin,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [31:0] bcd_out
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [31:0] sreg;
  logic [39:0] acc, adj;
  logic [4:0] cnt;
  logic mode, hold;
  genvar d;
  generate
    for (d = 0; d < 10; d++) begin : g_adj
      assign adj[4*d+:4] = acc[4*d+:4] >= 4'd5 ? acc[4*d+:4] + 4'd3 : acc[4*d+:4];
    end
  endgenerate
  assign busy = state != IDLE;
  // next state: hex requests hold DONE one extra cycle before releasing the word
  always_comb begin
    state_nx = state == IDLE  ? (start ? (hex_mode ? DONE : SHIFT) : IDLE) :
               state == SHIFT ? (cnt == 5'd31 ? DONE : SHIFT) :
               (mode && !hold) ? DONE : IDLE;
  end
  // datapath: capture operand, one double-dabble iteration per cycle, publish result
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      done     <= 1'b0;
      overflow <= 1'b0;
      bcd_out  <= '0;
      sreg     <= '0;
      acc      <= '0;
      cnt      <= '0;
      mode     <= 1'b0;
      hold     <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sreg <= bin;
          acc  <= '0;
          cnt  <= '0;
          mode <= hex_mode;
          hold <= 1'b0;
        end
        SHIFT: begin
          acc  <= {adj[38:0], sreg[31]};
          sreg <= sreg << 1;
          cnt  <= cnt + 5'd1;
        end
        DONE: if (mode && !hold) hold <= 1'b1;
        else begin
          done     <= 1'b1;
          overflow <= !mode && |acc[39:32];
          bcd_out  <= mode ? sreg : |acc[39:32] ? ERR_PATTERN : acc[31:0];
        end
        default: ;
      endcase
    end
  end
endmodule
